// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard controller.
// The optional statistics block is enabled with the HAZARD_PERF_EN macro.
package hazard_pkg;

    localparam int FWD_E     = 0;
    localparam int FWD_M     = 1;
    localparam int FWD_W     = 2;
    localparam int PERF_W    = 32;
    localparam int SEL_W_DEF = 2;

    typedef logic [SEL_W_DEF-1:0] fwd_sel_t;
    typedef logic [PERF_W-1:0]    perf_cnt_t;

    typedef enum logic [2:0] {
        ST_F,
        ST_D,
        ST_E,
        ST_M,
        ST_W
    } stage_t;

    function automatic perf_cnt_t perfInc(input perf_cnt_t cnt, input logic en);
        return en ? cnt + perf_cnt_t'(1) : cnt;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard for long-latency ops plus an outstanding-op counter.
// Lookups see a same-cycle writeback as already released.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_N    = 32,
    parameter int REG_AW   = $clog2(REG_N),
    parameter int LONG_MAX = 2,
    parameter int CNT_W    = $clog2(LONG_MAX + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              setEn,
    input  logic [REG_AW-1:0] setReg,
    input  logic              clrEn,
    input  logic [REG_AW-1:0] clrReg,
    input  logic              kill,
    input  logic              incEn,
    input  logic [REG_AW-1:0] rdAddr [3],
    output logic [2:0]        rdHit,
    output logic [CNT_W-1:0]  longCnt
);

    logic [REG_N-1:0] pendReg, pendNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic             decEn;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lookup
            assign rdHit[gi] = pendReg[rdAddr[gi]] & ~(clrEn & (clrReg == rdAddr[gi]));
        end
    endgenerate

    // A writeback with nothing outstanding is ignored so the counter cannot underflow.
    assign decEn = clrEn & (cntReg != '0);

    always_comb begin
        pendNext = pendReg;
        cntNext  = cntReg;
        if (kill) begin
            pendNext = '0;
            cntNext  = '0;
        end else begin
            if (clrEn) pendNext[clrReg] = 1'b0;
            if (setEn) pendNext[setReg] = 1'b1;
            if (incEn && !decEn)      cntNext = cntReg + CNT_W'(1);
            else if (!incEn && decEn) cntNext = cntReg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pendReg <= '0;
            cntReg  <= '0;
        end else begin
            pendReg <= pendNext;
            cntReg  <= cntNext;
        end
    end

    assign longCnt = cntReg;

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard controller: forwarding select, load/scoreboard stalls, exception replay.
// Define HAZARD_PERF_EN to build the statistics counters; otherwise the perf ports read 0.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int REG_N    = 32,
    parameter int REG_AW   = $clog2(REG_N),
    parameter int FWD_N    = 3,
    parameter int LONG_MAX = 2,
    parameter int SEL_W    = $clog2(FWD_N + 1)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [REG_AW-1:0]       rs_d,
    input  logic [REG_AW-1:0]       rt_d,
    input  logic                    use_rs_d,
    input  logic                    use_rt_d,
    input  logic [FWD_N*REG_AW-1:0] fwd_wreg,
    input  logic [FWD_N-1:0]        fwd_wen,
    input  logic [FWD_N-1:0]        fwd_rdy,
    output logic [SEL_W-1:0]        fwd_sel_a,
    output logic [SEL_W-1:0]        fwd_sel_b,
    input  logic [REG_AW-1:0]       wreg_d,
    input  logic                    wen_d,
    input  logic                    long_d,
    input  logic                    long_done,
    input  logic [REG_AW-1:0]       long_wreg,
    output logic                    long_busy,
    output logic                    long_kill,
    input  logic                    stall_all,
    input  logic                    exc_m,
    input  logic                    pmis_m,
    output logic                    stall_d,
    output logic                    stall_e,
    output logic                    stall_m,
    output logic                    stall_w,
    output logic                    flush_d,
    output logic                    flush_e,
    output logic                    flush_m,
    output logic                    flush_w,
    output logic [31:0]             perf_ld_cnt,
    output logic [31:0]             perf_sb_cnt,
    output logic [31:0]             perf_exc_cnt
);

    localparam int CNT_W = $clog2(LONG_MAX + 1);

    logic [FWD_N-1:0]  matchA, matchB;
    logic [SEL_W-1:0]  selA, selB;
    logic              rdyA, rdyB;
    logic              ldStall, sbStall, stStall, hzD;
    logic              excPendReg, excTake, issue;
    logic [2:0]        sbHit;
    logic [REG_AW-1:0] sbAddr [3];
    logic [CNT_W-1:0]  longCnt;

    genvar gi;
    generate
        for (gi = 0; gi < FWD_N; gi++) begin : g_match
            assign matchA[gi] = fwd_wen[gi] && (fwd_wreg[gi*REG_AW +: REG_AW] == rs_d) && (rs_d != '0);
            assign matchB[gi] = fwd_wen[gi] && (fwd_wreg[gi*REG_AW +: REG_AW] == rt_d) && (rt_d != '0);
        end
    endgenerate

    // Scan oldest to youngest so the youngest matching source wins.
    always_comb begin
        selA = '0;
        selB = '0;
        rdyA = 1'b1;
        rdyB = 1'b1;
        for (int k = FWD_N - 1; k >= 0; k--) begin
            if (matchA[k]) begin
                selA = SEL_W'(k + 1);
                rdyA = fwd_rdy[k];
            end
            if (matchB[k]) begin
                selB = SEL_W'(k + 1);
                rdyB = fwd_rdy[k];
            end
        end
    end

    assign sbAddr[0] = rs_d;
    assign sbAddr[1] = rt_d;
    assign sbAddr[2] = wreg_d;

    hazard_scoreboard #(
        .REG_N   (REG_N),
        .REG_AW  (REG_AW),
        .LONG_MAX(LONG_MAX),
        .CNT_W   (CNT_W)
    ) u_sb (
        .clk    (clk),
        .resetn (resetn),
        .setEn  (issue & long_d & wen_d & (wreg_d != '0)),
        .setReg (wreg_d),
        .clrEn  (long_done),
        .clrReg (long_wreg),
        .kill   (excTake),
        .incEn  (issue & long_d),
        .rdAddr (sbAddr),
        .rdHit  (sbHit),
        .longCnt(longCnt)
    );

    assign ldStall = (use_rs_d & ~rdyA) | (use_rt_d & ~rdyB);
    assign sbStall = (use_rs_d & sbHit[0]) | (use_rt_d & sbHit[1]) | (wen_d & sbHit[2]);
    assign stStall = long_d & (longCnt == CNT_W'(LONG_MAX));
    assign hzD     = ldStall | sbStall | stStall;

    assign excTake = (exc_m | excPendReg) & ~stall_all;
    assign issue   = ~hzD & ~stall_all & ~excTake;

    // An exception seen under a global stall is replayed on the first free cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                excPendReg <= 1'b0;
        else if (excTake)           excPendReg <= 1'b0;
        else if (exc_m & stall_all) excPendReg <= 1'b1;
    end

    assign fwd_sel_a = selA;
    assign fwd_sel_b = selB;
    assign long_busy = (longCnt != '0);
    assign long_kill = excTake;
    assign stall_d   = (hzD | stall_all) & ~excTake;
    assign stall_e   = stall_all;
    assign stall_m   = stall_all;
    assign stall_w   = stall_all;
    assign flush_d   = excTake;
    assign flush_e   = excTake | ((hzD | pmis_m) & ~stall_all);
    assign flush_m   = excTake;
    assign flush_w   = 1'b0;

`ifdef HAZARD_PERF_EN
    perf_cnt_t perfLdReg, perfSbReg, perfExcReg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perfLdReg  <= '0;
            perfSbReg  <= '0;
            perfExcReg <= '0;
        end else begin
            perfLdReg  <= perfInc(perfLdReg, ldStall & ~stall_all);
            perfSbReg  <= perfInc(perfSbReg, sbStall | stStall);
            perfExcReg <= perfInc(perfExcReg, excTake);
        end
    end

    assign perf_ld_cnt  = perfLdReg;
    assign perf_sb_cnt  = perfSbReg;
    assign perf_exc_cnt = perfExcReg;
`else
    assign perf_ld_cnt  = '0;
    assign perf_sb_cnt  = '0;
    assign perf_exc_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: forwarding, load-use, scoreboard, issue limit, exception replay, reset.
// Perf expectations follow HAZARD_PERF_EN as defined for the build.
module tb_hazard_sb;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  rs_d, rt_d, wreg_d, long_wreg;
    logic        use_rs_d, use_rt_d, wen_d, long_d, long_done;
    logic [14:0] fwd_wreg;
    logic [2:0]  fwd_wen, fwd_rdy;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        long_busy, long_kill, stall_all, exc_m, pmis_m;
    logic        stall_d, stall_e, stall_m, stall_w;
    logic        flush_d, flush_e, flush_m, flush_w;
    logic [31:0] perf_ld_cnt, perf_sb_cnt, perf_exc_cnt;

    int checks   = 0;
    int failures = 0;
    int expLd    = 0;
    int expSb    = 0;
    int expExc   = 0;

    always #5 clk = ~clk;

    hazard_sb dut (
        .clk(clk), .resetn(resetn),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .fwd_wreg(fwd_wreg), .fwd_wen(fwd_wen), .fwd_rdy(fwd_rdy),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .wreg_d(wreg_d), .wen_d(wen_d), .long_d(long_d),
        .long_done(long_done), .long_wreg(long_wreg),
        .long_busy(long_busy), .long_kill(long_kill),
        .stall_all(stall_all), .exc_m(exc_m), .pmis_m(pmis_m),
        .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
        .perf_ld_cnt(perf_ld_cnt), .perf_sb_cnt(perf_sb_cnt), .perf_exc_cnt(perf_exc_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic idle();
        rs_d = '0; rt_d = '0; use_rs_d = 0; use_rt_d = 0;
        wreg_d = '0; wen_d = 0; long_d = 0; long_done = 0; long_wreg = '0;
        fwd_wreg = '0; fwd_wen = '0; fwd_rdy = '0;
        stall_all = 0; exc_m = 0; pmis_m = 0;
    endtask

    task automatic setFwd(input logic [4:0] e, input logic [4:0] m, input logic [4:0] w,
                          input logic [2:0] wen, input logic [2:0] rdy);
        fwd_wreg = {w, m, e};
        fwd_wen  = wen;
        fwd_rdy  = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        resetn = 0;
        #12;
        chk("rst_long_busy", long_busy, 0);
        chk("rst_long_kill", long_kill, 0);
        chk("rst_flush_e", flush_e, 0);
        chk("rst_flush_d", flush_d, 0);
        resetn = 1;
        tick();

        // Load-use on r8: one bubble, then forwarded from M.
        setFwd(5'd8, 5'd0, 5'd0, 3'b001, 3'b000);
        rs_d = 5'd8; use_rs_d = 1; #1;
        chk("ld_sel_a", fwd_sel_a, 1);
        chk("ld_stall_d", stall_d, 1);
        chk("ld_flush_e", flush_e, 1);
        expLd++;
        tick();
        setFwd(5'd0, 5'd8, 5'd0, 3'b010, 3'b010); #1;
        chk("ld_next_sel_a", fwd_sel_a, 2);
        chk("ld_next_stall_d", stall_d, 0);
        chk("ld_next_flush_e", flush_e, 0);
        tick();

        // r0 never forwards; an unused operand never stalls.
        idle();
        setFwd(5'd0, 5'd0, 5'd0, 3'b111, 3'b000);
        use_rs_d = 1; use_rt_d = 1; #1;
        chk("r0_sel_a", fwd_sel_a, 0);
        chk("r0_sel_b", fwd_sel_b, 0);
        chk("r0_stall_d", stall_d, 0);
        idle();
        setFwd(5'd8, 5'd0, 5'd0, 3'b001, 3'b000);
        rt_d = 5'd8; #1;
        chk("unused_sel_b", fwd_sel_b, 1);
        chk("unused_stall_d", stall_d, 0);
        idle();
        setFwd(5'd9, 5'd9, 5'd4, 3'b111, 3'b111);
        rs_d = 5'd9; rt_d = 5'd4; use_rs_d = 1; use_rt_d = 1; #1;
        chk("prio_sel_a", fwd_sel_a, 1);
        chk("prio_sel_b", fwd_sel_b, 3);
        chk("pmis_flush_e", flush_e, 0);
        pmis_m = 1; #1;
        chk("pmis_flush_e", flush_e, 1);
        chk("pmis_stall_d", stall_d, 0);
        tick();

        // div r5, then dependent addu r6,r5,r1 waits for the writeback.
        idle();
        long_d = 1; wen_d = 1; wreg_d = 5'd5; #1;
        chk("div_issue_stall_d", stall_d, 0);
        tick();
        idle();
        rs_d = 5'd5; rt_d = 5'd1; use_rs_d = 1; use_rt_d = 1; wreg_d = 5'd6; wen_d = 1; #1;
        chk("div_busy", long_busy, 1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("div_dep_stall_%0d", i), stall_d, 1);
            expSb++;
            tick();
        end
        long_done = 1; long_wreg = 5'd5;
        setFwd(5'd0, 5'd0, 5'd5, 3'b100, 3'b100); #1;
        chk("div_release_stall_d", stall_d, 0);
        chk("div_release_sel_a", fwd_sel_a, 3);
        tick();
        idle(); #1;
        chk("div_done_busy", long_busy, 0);

        // Outstanding-op limit of 2.
        long_d = 1; wen_d = 1; wreg_d = 5'd10; #1;
        chk("lim_issue1", stall_d, 0);
        tick();
        wreg_d = 5'd11; #1;
        chk("lim_issue2", stall_d, 0);
        tick();
        wreg_d = 5'd12; long_done = 1; long_wreg = 5'd10; #1;
        chk("lim_full_no_bypass", stall_d, 1);
        chk("lim_full_flush_e", flush_e, 1);
        expSb++;
        tick();
        long_wreg = 5'd11; #1;
        chk("lim_issue_with_done", stall_d, 0);
        tick();
        long_done = 0; wreg_d = 5'd13; #1;
        chk("lim_cnt_held", stall_d, 0);
        tick();
        wreg_d = 5'd14; #1;
        chk("lim_full_again", stall_d, 1);
        expSb++;
        tick();

        // Exception under a 4-cycle global stall is replayed afterwards.
        idle();
        stall_all = 1; exc_m = 1; #1;
        chk("exc_hold_flush_d", flush_d, 0);
        chk("exc_hold_flush_e", flush_e, 0);
        chk("exc_hold_kill", long_kill, 0);
        chk("exc_hold_stall_d", stall_d, 1);
        chk("exc_hold_stall_e", stall_e, 1);
        tick();
        exc_m = 0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("exc_pend_flush_m_%0d", i), flush_m, 0);
            tick();
        end
        stall_all = 0; #1;
        chk("exc_take_flush_d", flush_d, 1);
        chk("exc_take_flush_e", flush_e, 1);
        chk("exc_take_flush_m", flush_m, 1);
        chk("exc_take_flush_w", flush_w, 0);
        chk("exc_take_kill", long_kill, 1);
        chk("exc_take_stall_d", stall_d, 0);
        chk("exc_take_stall_m", stall_m, 0);
        expExc++;
        tick();
        chk("exc_after_kill", long_kill, 0);
        chk("exc_after_busy", long_busy, 0);
        chk("exc_after_flush_d", flush_d, 0);
        rs_d = 5'd12; use_rs_d = 1; wreg_d = 5'd13; wen_d = 1; long_d = 1; #1;
        chk("exc_sb_cleared", stall_d, 0);
        idle();

        // Two more load-use stalls, then one under global stall that perf ignores.
        for (int i = 0; i < 2; i++) begin
            setFwd(5'd7, 5'd0, 5'd0, 3'b001, 3'b000);
            rs_d = 5'd7; use_rs_d = 1; #1;
            chk($sformatf("ld2_stall_d_%0d", i), stall_d, 1);
            expLd++;
            tick();
            idle();
            tick();
        end
        setFwd(5'd7, 5'd0, 5'd0, 3'b001, 3'b000);
        rs_d = 5'd7; use_rs_d = 1; stall_all = 1; #1;
        chk("ld_gstall_stall_d", stall_d, 1);
        chk("ld_gstall_flush_e", flush_e, 0);
        tick();
        idle(); #1;

`ifdef HAZARD_PERF_EN
        chk("perf_ld", perf_ld_cnt, expLd);
        chk("perf_sb", perf_sb_cnt, expSb);
        chk("perf_exc", perf_exc_cnt, expExc);
`else
        chk("perf_ld_off", perf_ld_cnt, 0);
        chk("perf_sb_off", perf_sb_cnt, 0);
        chk("perf_exc_off", perf_exc_cnt, 0);
`endif

        // Asynchronous reset mid-operation clears everything with no kill pulse.
        long_d = 1; wen_d = 1; wreg_d = 5'd20; #1;
        chk("arst_issue", stall_d, 0);
        tick();
        idle();
        stall_all = 1; exc_m = 1; #1;
        chk("arst_busy_before", long_busy, 1);
        tick();
        resetn = 0; #1;
        chk("arst_busy", long_busy, 0);
        chk("arst_kill", long_kill, 0);
        idle(); #1;
        chk("arst_pend_cleared", flush_d, 0);
        resetn = 1;
        rs_d = 5'd20; use_rs_d = 1; #1;
        chk("arst_sb_cleared", stall_d, 0);
        chk("arst_perf_ld", perf_ld_cnt, 0);
        chk("arst_perf_exc", perf_exc_cnt, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
